// File: rtl/dma_pkg.sv
// Shared encodings for the REU DMA sequencer: transfer modes, FSM states, per-edge actions.
// Pure declarations; no latency, no backpressure.
package dma_pkg;

    typedef enum logic [1:0] {
        MODE_STASH  = 2'b00,
        MODE_FETCH  = 2'b01,
        MODE_SWAP   = 2'b10,
        MODE_VERIFY = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_XFER,
        ST_SWAPW,
        ST_TAIL,
        ST_FINISH
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_GRANT,
        ACT_BYTE,
        ACT_SWAPW,
        ACT_TAIL,
        ACT_FINISH,
        ACT_FAIL,
        ACT_IDLE
    } act_t;

    localparam logic [16:0] LEN_MAX = 17'h10000;

    // A programmed length of zero stands for a full 64 KiB transfer.
    function automatic logic [16:0] len_load(input logic [15:0] base);
        return (base == 16'h0000) ? LEN_MAX : {1'b0, base};
    endfunction

endpackage

// File: rtl/dma_addr_ctr.sv
// Loadable wrapping up-counter for DMA addresses; load wins over increment, hold freezes it.
// Latency: one clock from load/inc to q; no backpressure.
module dma_addr_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc && !hold) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/dma_seq.sv
// REU DMA sequencer: one byte per PHI2 cycle (two for swap); all outputs but DONE move on PHI2Fall edges.
// Latency: GO -> DMAREQ at next PHI2Fall, first byte one PHI2 cycle later; BA low inserts stall cycles.
module dma_seq
    import dma_pkg::*;
(
    input  logic        C8M,
    input  logic        RESET,
    input  logic        PHI2Fall,
    input  logic        GO,
    input  logic [1:0]  MODE,
    input  logic [15:0] C64Base,
    input  logic [23:0] REUBase,
    input  logic [15:0] LenBase,
    input  logic        FixC64,
    input  logic        FixREU,
    input  logic        AutoLoad,
    input  logic        BA,
    input  logic        CMPEQ,
    output logic        RDCMD,
    output logic        WRCMD,
    output logic [23:0] A,
    output logic [15:0] CA,
    output logic        CRW,
    output logic        CBUSEN,
    output logic        DMAREQ,
    output logic        BUSY,
    output logic        DONE,
    output logic        VERR,
    output logic [15:0] CurC64,
    output logic [23:0] CurREU,
    output logic [15:0] CurLen
);

    state_t      state;
    mode_t       xmode;
    act_t        act;
    logic        stall;
    logic        armed;
    logic [16:0] len;
    logic        wpend;
    logic [23:0] waddr;
    logic        ld_cnt;
    logic        inc_cnt;

    // len is decremented when a byte starts, so zero here means the byte just closing was the last.
    always_comb begin
        act = ACT_NONE;
        case (state)
            ST_IDLE:   if (armed) act = ACT_GRANT;
            ST_GRANT:  act = ACT_BYTE;
            ST_XFER: begin
                if (stall)                                 act = ACT_BYTE;
                else if (xmode == MODE_SWAP)               act = ACT_SWAPW;
                else if (xmode == MODE_VERIFY && !CMPEQ)   act = ACT_FAIL;
                else if (len == 17'd0)                     act = (xmode == MODE_STASH) ? ACT_TAIL : ACT_FINISH;
                else                                       act = ACT_BYTE;
            end
            ST_SWAPW: begin
                if (stall)             act = ACT_SWAPW;
                else if (len == 17'd0) act = ACT_FINISH;
                else                   act = ACT_BYTE;
            end
            ST_TAIL:   act = ACT_FINISH;
            ST_FINISH: act = ACT_IDLE;
            default:   act = ACT_NONE;
        endcase
    end

    assign ld_cnt  = PHI2Fall && ((act == ACT_GRANT) ||
                                  (((act == ACT_FINISH) || (act == ACT_FAIL)) && AutoLoad));
    assign inc_cnt = PHI2Fall && (act == ACT_BYTE) && BA;
    assign CurLen  = len[15:0];

    dma_addr_ctr #(.W(16)) u_c64_ctr (
        .clk      (C8M),
        .rst      (RESET),
        .load     (ld_cnt),
        .load_val (C64Base),
        .inc      (inc_cnt),
        .hold     (FixC64),
        .q        (CurC64)
    );

    dma_addr_ctr #(.W(24)) u_reu_ctr (
        .clk      (C8M),
        .rst      (RESET),
        .load     (ld_cnt),
        .load_val (REUBase),
        .inc      (inc_cnt),
        .hold     (FixREU),
        .q        (CurREU)
    );

    always_ff @(posedge C8M) begin
        if (RESET) begin
            state  <= ST_IDLE;
            xmode  <= MODE_STASH;
            stall  <= 1'b0;
            armed  <= 1'b0;
            len    <= '0;
            wpend  <= 1'b0;
            waddr  <= '0;
            RDCMD  <= 1'b0;
            WRCMD  <= 1'b0;
            A      <= '0;
            CA     <= '0;
            CRW    <= 1'b1;
            CBUSEN <= 1'b0;
            DMAREQ <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            VERR   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            // GO is remembered until the next PHI2 boundary so every visible change stays phase-aligned.
            if (GO && (state == ST_IDLE) && !armed) armed <= 1'b1;
            if (PHI2Fall) begin
                case (act)
                    ACT_GRANT: begin
                        state  <= ST_GRANT;
                        armed  <= 1'b0;
                        xmode  <= mode_t'(MODE);
                        len    <= len_load(LenBase);
                        VERR   <= 1'b0;
                        DMAREQ <= 1'b1;
                        BUSY   <= 1'b1;
                    end
                    ACT_BYTE: begin
                        state <= ST_XFER;
                        stall <= !BA;
                        if (!BA) begin
                            // VIC owns the bus: only a deferred stash write may still go to SDRAM.
                            CBUSEN <= 1'b0;
                            RDCMD  <= 1'b0;
                            CRW    <= 1'b1;
                            WRCMD  <= wpend;
                            if (wpend) A <= waddr;
                            wpend  <= 1'b0;
                        end else begin
                            CA     <= CurC64;
                            len    <= len - 17'd1;
                            CBUSEN <= 1'b1;
                            case (xmode)
                                MODE_STASH: begin
                                    RDCMD <= 1'b0;
                                    CRW   <= 1'b1;
                                    WRCMD <= wpend;
                                    if (wpend) A <= waddr;
                                    waddr <= CurREU;
                                    wpend <= 1'b1;
                                end
                                MODE_FETCH: begin
                                    RDCMD <= 1'b1;
                                    WRCMD <= 1'b0;
                                    CRW   <= 1'b0;
                                    A     <= CurREU;
                                end
                                default: begin
                                    RDCMD <= 1'b1;
                                    WRCMD <= 1'b0;
                                    CRW   <= 1'b1;
                                    A     <= CurREU;
                                end
                            endcase
                        end
                    end
                    ACT_SWAPW: begin
                        state  <= ST_SWAPW;
                        stall  <= !BA;
                        RDCMD  <= 1'b0;
                        WRCMD  <= BA;
                        CRW    <= !BA;
                        CBUSEN <= BA;
                    end
                    ACT_TAIL: begin
                        state  <= ST_TAIL;
                        CBUSEN <= 1'b0;
                        RDCMD  <= 1'b0;
                        WRCMD  <= 1'b1;
                        CRW    <= 1'b1;
                        A      <= waddr;
                        wpend  <= 1'b0;
                    end
                    ACT_FINISH, ACT_FAIL: begin
                        state  <= ST_FINISH;
                        stall  <= 1'b0;
                        wpend  <= 1'b0;
                        DMAREQ <= 1'b0;
                        CBUSEN <= 1'b0;
                        RDCMD  <= 1'b0;
                        WRCMD  <= 1'b0;
                        CRW    <= 1'b1;
                        DONE   <= 1'b1;
                        if (act == ACT_FAIL) VERR <= 1'b1;
                        if (AutoLoad) len <= len_load(LenBase);
                    end
                    ACT_IDLE: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_seq.sv
// Randomised and directed bench for dma_seq against a per-byte schedule model of the transfer rules.
module tb_dma_seq;
    import dma_pkg::*;

    logic        C8M = 1'b0;
    logic        RESET, PHI2Fall, GO;
    logic [1:0]  MODE;
    logic [15:0] C64Base, LenBase;
    logic [23:0] REUBase;
    logic        FixC64, FixREU, AutoLoad, BA, CMPEQ;
    logic        RDCMD, WRCMD, CRW, CBUSEN, DMAREQ, BUSY, DONE, VERR;
    logic [23:0] A, CurREU;
    logic [15:0] CA, CurC64, CurLen;

    always #5 C8M = ~C8M;

    dma_seq dut (
        .C8M(C8M), .RESET(RESET), .PHI2Fall(PHI2Fall), .GO(GO), .MODE(MODE),
        .C64Base(C64Base), .REUBase(REUBase), .LenBase(LenBase),
        .FixC64(FixC64), .FixREU(FixREU), .AutoLoad(AutoLoad), .BA(BA), .CMPEQ(CMPEQ),
        .RDCMD(RDCMD), .WRCMD(WRCMD), .A(A), .CA(CA), .CRW(CRW), .CBUSEN(CBUSEN),
        .DMAREQ(DMAREQ), .BUSY(BUSY), .DONE(DONE), .VERR(VERR),
        .CurC64(CurC64), .CurREU(CurREU), .CurLen(CurLen)
    );

    typedef struct packed {
        logic        rd, wr, crw, cben, dmareq, busy, done, verr;
        logic [23:0] a;
        logic [15:0] ca;
    } cyc_t;

    cyc_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          div   = 4;
    bit          go_inj = 1'b0;
    bit          ba_tab [256];
    bit          cmp_tab[256];
    logic [23:0] m_a, m_curr;
    logic [15:0] m_ca, m_curc, m_curl;
    logic        m_verr;

    function automatic cyc_t obs();
        cyc_t o;
        o.rd = RDCMD; o.wr = WRCMD; o.crw = CRW; o.cben = CBUSEN;
        o.dmareq = DMAREQ; o.busy = BUSY; o.done = DONE; o.verr = VERR;
        o.a = A; o.ca = CA;
        return o;
    endfunction

    function automatic bit ba_at(input int e);
        return (e < 256) ? ba_tab[e] : 1'b1;
    endfunction

    function automatic bit cmp_at(input int e);
        return (e < 256) ? cmp_tab[e] : 1'b1;
    endfunction

    task automatic check_rec(input string tag, input int e, input cyc_t o, input cyc_t x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, o, x);
        end
    endtask

    task automatic check_val(input string tag, input logic [23:0] o, input logic [23:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    task automatic tick(input logic pf);
        PHI2Fall = pf;
        @(posedge C8M);
        #1;
        PHI2Fall = 1'b0;
    endtask

    task automatic push(input logic rd, wr, crw, cben, dmareq, busy, done);
        cyc_t r;
        r.rd = rd; r.wr = wr; r.crw = crw; r.cben = cben;
        r.dmareq = dmareq; r.busy = busy; r.done = done; r.verr = m_verr;
        r.a = m_a; r.ca = m_ca;
        exp_q.push_back(r);
    endtask

    // One record per PHI2 cycle starting with GRANT; record index == PHI2Fall edge index.
    task automatic build_model(input logic [1:0] md, input logic [15:0] cb, input logic [23:0] rb,
                               input logic [15:0] lb, input logic fc, input logic fr, input logic al);
        int n, nb;
        bit pend, fail;
        logic [23:0] paddr, ra;
        logic [15:0] c;
        exp_q.delete();
        n = (lb == 16'h0) ? 65536 : int'(lb);
        nb = 0; pend = 1'b0; fail = 1'b0; paddr = '0;
        m_verr = 1'b0;
        push(0, 0, 1, 0, 1, 1, 0);
        for (int k = 0; k < n && !fail; k++) begin
            c  = fc ? cb : cb + 16'(k);
            ra = fr ? rb : rb + 24'(k);
            while (!ba_at(exp_q.size())) begin
                if (pend) m_a = paddr;
                push(0, pend, 1, 0, 1, 1, 0);
                pend = 1'b0;
            end
            m_ca = c;
            case (md)
                2'b00: begin
                    if (pend) m_a = paddr;
                    push(0, pend, 1, 1, 1, 1, 0);
                    paddr = ra;
                    pend = 1'b1;
                end
                2'b01: begin
                    m_a = ra;
                    push(1, 0, 0, 1, 1, 1, 0);
                end
                2'b11: begin
                    m_a = ra;
                    push(1, 0, 1, 1, 1, 1, 0);
                    if (!cmp_at(exp_q.size())) fail = 1'b1;
                end
                default: begin
                    m_a = ra;
                    push(1, 0, 1, 1, 1, 1, 0);
                    while (!ba_at(exp_q.size())) push(0, 0, 1, 0, 1, 1, 0);
                    push(0, 1, 0, 1, 1, 1, 0);
                end
            endcase
            nb++;
        end
        if (md == 2'b00) begin
            m_a = paddr;
            push(0, 1, 1, 0, 1, 1, 0);
        end
        m_verr = fail;
        push(0, 0, 1, 0, 0, 1, 1);
        push(0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 1, 0, 0, 0, 0);
        if (al) begin
            m_curc = cb; m_curr = rb; m_curl = lb;
        end else begin
            m_curc = fc ? cb : cb + 16'(nb);
            m_curr = fr ? rb : rb + 24'(nb);
            m_curl = 16'(n - nb);
        end
    endtask

    task automatic setup(input logic [1:0] md, input logic [15:0] cb, input logic [23:0] rb,
                         input logic [15:0] lb, input logic fc, input logic fr, input logic al);
        MODE = md; C64Base = cb; REUBase = rb; LenBase = lb;
        FixC64 = fc; FixREU = fr; AutoLoad = al;
        build_model(md, cb, rb, lb, fc, fr, al);
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < 256; i++) begin
            ba_tab[i] = 1'b1;
            cmp_tab[i] = 1'b1;
        end
    endtask

    task automatic start_go();
        GO = 1'b1;
        tick(div == 1);
        GO = 1'b0;
    endtask

    task automatic step(input int e, input bit quiet, output bit mis);
        cyc_t o, x;
        mis = 1'b0;
        BA = ba_at(e);
        CMPEQ = cmp_at(e);
        for (int t = 0; t < div - 1; t++) begin
            GO = go_inj && (e == 3) && (t == 0);
            tick(1'b0);
            GO = 1'b0;
        end
        if (e > 0 && div > 1) begin
            x = exp_q[e-1];
            x.done = 1'b0;
            o = obs();
            if (quiet) mis = (o !== x);
            else check_rec("hold", e, o, x);
        end
        tick(1'b1);
        o = obs();
        x = exp_q[e];
        if (quiet) mis = mis | (o !== x);
        else check_rec("cycle", e, o, x);
    endtask

    task automatic run_xfer(input bit quiet);
        int nerr;
        bit mis;
        nerr = 0;
        start_go();
        for (int e = 0; e < exp_q.size(); e++) begin
            step(e, quiet, mis);
            if (mis) nerr++;
        end
        if (quiet) check_val("long_trace_mismatches", 24'(nerr), 24'd0);
        check_val("cur_c64", {8'h0, CurC64}, {8'h0, m_curc});
        check_val("cur_reu", CurREU, m_curr);
        check_val("cur_len", {8'h0, CurLen}, {8'h0, m_curl});
    endtask

    initial begin
        cyc_t rst_rec;
        bit   mis;
        RESET = 1'b1; PHI2Fall = 1'b0; GO = 1'b0; MODE = 2'b00;
        C64Base = '0; REUBase = '0; LenBase = '0;
        FixC64 = 1'b0; FixREU = 1'b0; AutoLoad = 1'b0; BA = 1'b1; CMPEQ = 1'b1;
        m_a = '0; m_ca = '0; m_verr = 1'b0; m_curc = '0; m_curr = '0; m_curl = '0;
        clear_tabs();
        rst_rec = '0;
        rst_rec.crw = 1'b1;
        repeat (3) tick(1'b0);
        check_rec("reset_outputs", 0, obs(), rst_rec);
        RESET = 1'b0;
        tick(1'b1);
        check_rec("idle_after_reset", 0, obs(), rst_rec);
        check_val("reset_cur_c64", {8'h0, CurC64}, 24'h0);
        check_val("reset_cur_reu", CurREU, 24'h0);

        // fetch, 3 bytes
        setup(2'b01, 16'hC000, 24'h000100, 16'd3, 1'b0, 1'b0, 1'b0);
        run_xfer(1'b0);
        check_val("fetch_end_reu", CurREU, 24'h000103);

        // stash, 2 bytes: write lags the C64 read by one cycle, last write in tail
        setup(2'b00, 16'h2000, 24'h0A0000, 16'd2, 1'b0, 1'b0, 1'b0);
        run_xfer(1'b0);

        // verify, 4 bytes, mismatch on the second byte
        clear_tabs();
        cmp_tab[3] = 1'b0;
        setup(2'b11, 16'h4000, 24'h012345, 16'd4, 1'b0, 1'b0, 1'b0);
        run_xfer(1'b0);
        check_val("verify_verr", {23'h0, VERR}, 24'h1);
        check_val("verify_c64", {8'h0, CurC64}, 24'h004002);
        check_val("verify_len", {8'h0, CurLen}, 24'h000002);

        // swap, 1 byte, fixed REU address, bus stolen at the start of the write cycle
        clear_tabs();
        ba_tab[2] = 1'b0;
        setup(2'b10, 16'h0800, 24'h070707, 16'd1, 1'b0, 1'b1, 1'b0);
        run_xfer(1'b0);
        check_val("swap_reu_fixed", CurREU, 24'h070707);

        // reset in the middle of a fetch, then a clean restart
        clear_tabs();
        setup(2'b01, 16'h1000, 24'h200000, 16'd5, 1'b0, 1'b0, 1'b0);
        start_go();
        for (int e = 0; e < 3; e++) step(e, 1'b0, mis);
        RESET = 1'b1;
        tick(1'b0);
        check_rec("reset_mid_xfer", 0, obs(), rst_rec);
        check_val("reset_mid_c64", {8'h0, CurC64}, 24'h0);
        check_val("reset_mid_len", {8'h0, CurLen}, 24'h0);
        RESET = 1'b0;
        m_a = '0; m_ca = '0; m_verr = 1'b0;
        tick(1'b1);
        setup(2'b01, 16'h1000, 24'h200000, 16'd2, 1'b0, 1'b0, 1'b0);
        run_xfer(1'b0);

        // randomised transfers: modes, wrap-prone bases, fix bits, bus steals, compare failures, stray GO
        for (int n = 0; n < 25; n++) begin
            logic [1:0]  md;
            logic [15:0] cb;
            logic [23:0] rb;
            div = $urandom_range(2, 4);
            go_inj = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 256; i++) begin
                ba_tab[i]  = (i < 40) ? ($urandom_range(0, 4) != 0) : 1'b1;
                cmp_tab[i] = ($urandom_range(0, 5) != 0);
            end
            md = 2'($urandom_range(0, 3));
            cb = ($urandom_range(0, 2) == 0) ? 16'hFFFD : 16'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? 24'hFFFFFC : 24'($urandom);
            setup(md, cb, rb, 16'($urandom_range(1, 8)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            run_xfer(1'b0);
            repeat ($urandom_range(0, 3)) tick(1'b0);
        end
        go_inj = 1'b0;

        // full 64 KiB fetch with PHI2Fall every clock, REU address wrapping through zero, reload at end
        div = 1;
        clear_tabs();
        setup(2'b01, 16'h1234, 24'hFFFF00, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_xfer(1'b1);
        check_val("long_reload_reu", CurREU, 24'hFFFF00);
        check_val("long_reload_c64", {8'h0, CurC64}, 24'h001234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
